// File: rtl/rof_pkg.sv
// Shared types and sizing helpers for the rank-order filter line feeder.
package rof_pkg;

  typedef enum logic [1:0] {
    PRE  = 2'd0,
    RUN  = 2'd1,
    POST = 2'd2
  } state_t;

  // Half window: number of replicated pad samples at each line end.
  function automatic int calc_h(input int n);
    return (n - 1) / 2;
  endfunction

  // pad_cnt reaches H at the end of the leading pads.
  function automatic int pad_w(input int n);
    return (calc_h(n) < 2) ? 1 : $clog2(calc_h(n) + 1);
  endfunction

  // sh_cnt saturates at N-1.
  function automatic int sh_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rof_out_buf.sv
// Two-entry result FIFO; each entry carries a data word plus its last flag.
module rof_out_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop & (cnt != 2'd0);
  assign do_push = push & ((cnt != 2'd2) | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/rof_line_feeder.sv
// Feeds line samples (with edge-replication padding) into the rank-order filter
// and returns one filter result per input sample on a valid/ready stream.
module rof_line_feeder
  import rof_pkg::*;
#(
  parameter int N         = 7,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_last,
  output logic                 f_shift,
  output logic [DATA_BITS-1:0] f_new,
  input  logic [DATA_BITS-1:0] f_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_last
);

  localparam int H  = calc_h(N);
  localparam int PW = pad_w(N);
  localparam int SW = sh_w(N);
  localparam logic [PW-1:0] PAD_LAST = PW'(H - 1);
  localparam logic [SW-1:0] SH_MAX   = SW'(N - 1);

  state_t               state;
  state_t               state_nxt;
  logic [PW-1:0]        pad_cnt;
  logic [SW-1:0]        sh_cnt;
  logic [DATA_BITS-1:0] last_reg;
  logic                 cap_pend;
  logic                 cap_last;
  logic [1:0]           buf_count;
  logic                 buf_empty;
  logic [DATA_BITS:0]   head;
  logic                 pop;
  logic                 can_shift;
  logic                 producing;
  logic                 room;
  logic                 final_shift;

  // Both streams transfer on a clock edge where valid and ready are both high;
  // ready never depends on the same stream's valid except in RUN, where the
  // input pop and the filter shift are one event.
  assign pop         = m_valid & m_ready;
  assign producing   = (sh_cnt == SH_MAX);
  assign can_shift   = ({1'b0, buf_count} + {2'b00, cap_pend}) <= (3'd1 + {2'b00, pop});
  assign room        = ~producing | can_shift;
  assign final_shift = (state == POST) && (pad_cnt == PAD_LAST);

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    f_shift   = 1'b0;
    f_new     = s_data;
    case (state)
      PRE: begin
        f_shift = s_valid;
        if (f_shift && pad_cnt == PAD_LAST) state_nxt = RUN;
      end
      RUN: begin
        s_ready = s_valid & room;
        f_shift = s_valid & room;
        if (f_shift && s_last) state_nxt = POST;
      end
      POST: begin
        f_new   = last_reg;
        f_shift = room;
        if (f_shift && final_shift) state_nxt = PRE;
      end
      default: state_nxt = PRE;
    endcase
    // Outputs must read as idle for the whole time reset is held.
    if (rst) begin
      s_ready = 1'b0;
      f_shift = 1'b0;
      f_new   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PRE;
      pad_cnt  <= '0;
      sh_cnt   <= '0;
      cap_pend <= 1'b0;
      cap_last <= 1'b0;
      last_reg <= '0;
    end else begin
      state    <= state_nxt;
      cap_pend <= f_shift & producing;
      cap_last <= f_shift & producing & final_shift;
      if (f_shift) begin
        case (state)
          PRE:  pad_cnt <= pad_cnt + PW'(1);
          RUN: begin
            if (s_last) begin
              pad_cnt  <= '0;
              last_reg <= s_data;
            end
          end
          POST: pad_cnt <= pad_cnt + PW'(1);
          default: pad_cnt <= '0;
        endcase
        if (!producing) sh_cnt <= sh_cnt + SW'(1);
        if (final_shift) begin
          sh_cnt  <= '0;
          pad_cnt <= '0;
        end
      end
    end
  end

  // The filter result is valid the cycle after a producing shift.
  rof_out_buf #(
    .W(DATA_BITS + 1)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_pend),
    .push_data ({cap_last, f_out}),
    .pop       (pop),
    .head      (head),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign m_valid = ~buf_empty;
  assign m_data  = head[DATA_BITS-1:0];
  assign m_last  = head[DATA_BITS] & m_valid;

endmodule
